// File: rtl/cpu_ctrl_pkg.sv
// Shared types and opcode constants for the pipelined control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

    localparam int CTRL_W   = 14;
    localparam int OPCODE_W = 11;

    // Field order is fixed: downstream muxes slice the flat word MSB..LSB.
    typedef struct packed {
        logic uncondBr;
        logic branch;
        logic branchReg;
        logic branchLink;
        logic reg2Loc;
        logic aluSrc;
        logic regWrite;
        logic aluSh;
        logic imm;
        logic memToReg;
        logic memWrite;
        logic shiftDirn;
        logic aluOn;
        logic setFlags;
    } ctrl_t;

    // Opcode match values. Short constants match only the top bits of the opcode.
    localparam logic [5:0]  OPC_B     = 6'b000101;          // op[10:5]
    localparam logic [7:0]  OPC_BCOND = 8'b01010100;        // op[10:3]
    localparam logic [5:0]  OPC_BL    = 6'b100101;          // op[10:5]
    localparam logic [10:0] OPC_BR    = 11'b11010110000;
    localparam logic [7:0]  OPC_CBZ   = 8'b10110100;        // op[10:3]
    localparam logic [9:0]  OPC_ADDI  = 10'b1001000100;     // op[10:1]
    localparam logic [10:0] OPC_ADDS  = 11'b10101011000;
    localparam logic [10:0] OPC_LDUR  = 11'b11111000010;
    localparam logic [10:0] OPC_STUR  = 11'b11111000000;
    localparam logic [10:0] OPC_SUBS  = 11'b11101011000;
    localparam logic [10:0] OPC_LSL   = 11'b11010011011;
    localparam logic [10:0] OPC_LSR   = 11'b11010011010;

    localparam ctrl_t CTRL_B     = 14'b10000000000000;
    localparam ctrl_t CTRL_BCOND = 14'b01000000000011;
    localparam ctrl_t CTRL_BL    = 14'b11010010000010;
    localparam ctrl_t CTRL_BR    = 14'b11100000000000;
    localparam ctrl_t CTRL_CBZ   = 14'b01000000000011;
    localparam ctrl_t CTRL_ADDI  = 14'b00000110100010;
    localparam ctrl_t CTRL_ADDS  = 14'b00001010000011;
    localparam ctrl_t CTRL_LDUR  = 14'b00000110010010;
    localparam ctrl_t CTRL_STUR  = 14'b00000100001010;
    localparam ctrl_t CTRL_SUBS  = 14'b00001010000011;
    localparam ctrl_t CTRL_LSL   = 14'b00000011000010;
    localparam ctrl_t CTRL_LSR   = 14'b00000011000110;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode decoder: 11-bit opcode -> ctrl_t plus legal flag, first match wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows opcode every cycle.
// Ports: opcode (in, 11) | ctrl (out, ctrl_t, zero when not legal) | legal (out, 1)
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int EN_SHIFT = 1
) (
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_t               ctrl,
    output logic                legal
);

    always_comb begin
        ctrl  = '0;
        legal = 1'b1;
        if (opcode[10:5] == OPC_B)                         ctrl = CTRL_B;
        else if (opcode[10:3] == OPC_BCOND)                ctrl = CTRL_BCOND;
        else if (opcode[10:5] == OPC_BL)                   ctrl = CTRL_BL;
        else if (opcode == OPC_BR)                         ctrl = CTRL_BR;
        else if (opcode[10:3] == OPC_CBZ)                  ctrl = CTRL_CBZ;
        else if (opcode[10:1] == OPC_ADDI)                 ctrl = CTRL_ADDI;
        else if (opcode == OPC_ADDS)                       ctrl = CTRL_ADDS;
        else if (opcode == OPC_LDUR)                       ctrl = CTRL_LDUR;
        else if (opcode == OPC_STUR)                       ctrl = CTRL_STUR;
        else if (opcode == OPC_SUBS)                       ctrl = CTRL_SUBS;
        else if ((EN_SHIFT != 0) && (opcode == OPC_LSL))   ctrl = CTRL_LSL;
        else if ((EN_SHIFT != 0) && (opcode == OPC_LSR))   ctrl = CTRL_LSR;
        else                                               legal = 1'b0;
    end

endmodule

// File: rtl/pipelined_ctrl_unit.sv
// Pipelined control unit: decodes ID opcode, carries ctrl word through N_STAGES registers, counts illegal ops.
// Latency: opcode captured into stage 0 at the next edge, then one stage per edge; no comb ID->output path.
// Backpressure: freeze holds all stages; stall/flush/illegal insert bubbles; the unit never stalls upstream itself.
// Ports: clk, rst (sync, active-low) | id_valid, opcode[10:0], stall, flush, freeze (in)
//        stage_valid[N], stage_ctrl[N*14], stage_opcode[N*11], illegal, illegal_cnt[CNT_W] (out)
module pipelined_ctrl_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int N_STAGES    = 3,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16,
    parameter int EN_SHIFT    = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid,
    input  logic [OPCODE_W-1:0]          opcode,
    input  logic                         stall,
    input  logic                         flush,
    input  logic                         freeze,
    output logic [N_STAGES-1:0]          stage_valid,
    output logic [N_STAGES*CTRL_W-1:0]   stage_ctrl,
    output logic [N_STAGES*OPCODE_W-1:0] stage_opcode,
    output logic                         illegal,
    output logic [CNT_W-1:0]             illegal_cnt
);

    ctrl_t               decCtrl;
    logic                decLegal;
    logic                accept;
    logic                illegalHit;

    logic                stValid [N_STAGES];
    ctrl_t               stCtrl  [N_STAGES];
    logic [OPCODE_W-1:0] stOp    [N_STAGES];

    ctrl_decode #(.EN_SHIFT(EN_SHIFT)) uDecode (
        .opcode (opcode),
        .ctrl   (decCtrl),
        .legal  (decLegal)
    );

    // An ID transfer only counts when nothing overrides it this edge.
    assign accept     = !freeze && !flush && !stall;
    assign illegalHit = accept && id_valid && !decLegal;

    for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (!rst) begin
                    stValid[0] <= 1'b0;
                    stCtrl[0]  <= '0;
                    stOp[0]    <= '0;
                end else if (!freeze) begin
                    if (flush || stall) begin
                        stValid[0] <= 1'b0;
                        stCtrl[0]  <= '0;
                        stOp[0]    <= '0;
                    end else begin
                        // Illegal opcodes decode to ctrl 0 and enter as a bubble.
                        stValid[0] <= id_valid && decLegal;
                        stCtrl[0]  <= decCtrl;
                        stOp[0]    <= opcode;
                    end
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk) begin
                if (!rst) begin
                    stValid[k] <= 1'b0;
                    stCtrl[k]  <= '0;
                    stOp[k]    <= '0;
                end else if (!freeze) begin
                    // Stages below FLUSH_DEPTH would receive a younger (killed) op on flush.
                    if (flush && (k < FLUSH_DEPTH)) begin
                        stValid[k] <= 1'b0;
                        stCtrl[k]  <= '0;
                        stOp[k]    <= '0;
                    end else begin
                        stValid[k] <= stValid[k-1];
                        stCtrl[k]  <= stCtrl[k-1];
                        stOp[k]    <= stOp[k-1];
                    end
                end
            end
        end

        assign stage_valid[k]                          = stValid[k];
        assign stage_ctrl[k*CTRL_W +: CTRL_W]          = stValid[k] ? stCtrl[k] : '0;
        assign stage_opcode[k*OPCODE_W +: OPCODE_W]    = stOp[k];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            illegal     <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            illegal <= illegalHit;
            if (illegalHit && (illegal_cnt != {CNT_W{1'b1}}))
                illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipelined_ctrl_unit.sv
// Bench for pipelined_ctrl_unit: two builds (EN_SHIFT=1 and EN_SHIFT=0, CNT_W=4) driven in lockstep.
// A reference model of the stage registers and a WB-stage scoreboard queue provide every expectation.
module tb_pipelined_ctrl_unit;

    localparam int NS = 3;
    localparam int FD = 2;
    localparam int CW = 4;

    localparam logic [10:0] B_OP    = 11'b00010100000;
    localparam logic [10:0] BC_OP   = 11'b01010100000;
    localparam logic [10:0] BL_OP   = 11'b10010100000;
    localparam logic [10:0] BR_OP   = 11'b11010110000;
    localparam logic [10:0] CBZ_OP  = 11'b10110100000;
    localparam logic [10:0] ADDI_OP = 11'b10010001000;
    localparam logic [10:0] ADDS_OP = 11'b10101011000;
    localparam logic [10:0] LDUR_OP = 11'b11111000010;
    localparam logic [10:0] STUR_OP = 11'b11111000000;
    localparam logic [10:0] SUBS_OP = 11'b11101011000;
    localparam logic [10:0] LSL_OP  = 11'b11010011011;
    localparam logic [10:0] LSR_OP  = 11'b11010011010;
    localparam logic [10:0] BAD_OP  = 11'b11111111111;

    logic clk = 1'b0;
    logic rst, id_valid, stall, flush, freeze;
    logic [10:0] opcode;

    logic [NS-1:0]    sv0, sv1;
    logic [NS*14-1:0] sc0, sc1;
    logic [NS*11-1:0] so0, so1;
    logic             ill0, ill1;
    logic [CW-1:0]    cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        mV [NS];
    logic [13:0] mC [NS];
    logic [10:0] mO [NS];
    logic        mIll, mIll1;
    int          mCnt, mCnt1;
    logic [24:0] sb [$];

    always #5 clk = ~clk;

    pipelined_ctrl_unit #(.N_STAGES(NS), .FLUSH_DEPTH(FD), .CNT_W(CW), .EN_SHIFT(1)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .stall(stall),
        .flush(flush), .freeze(freeze), .stage_valid(sv0), .stage_ctrl(sc0),
        .stage_opcode(so0), .illegal(ill0), .illegal_cnt(cnt0));

    pipelined_ctrl_unit #(.N_STAGES(NS), .FLUSH_DEPTH(FD), .CNT_W(CW), .EN_SHIFT(0)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .stall(stall),
        .flush(flush), .freeze(freeze), .stage_valid(sv1), .stage_ctrl(sc1),
        .stage_opcode(so1), .illegal(ill1), .illegal_cnt(cnt1));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Decode table transcribed from the opcode list.
    task automatic tbDec(input logic [10:0] op, input bit en, output logic [13:0] c, output logic l);
        l = 1'b1;
        casez (op)
            11'b000101?????: c = 14'b10000000000000;
            11'b01010100???: c = 14'b01000000000011;
            11'b100101?????: c = 14'b11010010000010;
            11'b11010110000: c = 14'b11100000000000;
            11'b10110100???: c = 14'b01000000000011;
            11'b1001000100?: c = 14'b00000110100010;
            11'b10101011000: c = 14'b00001010000011;
            11'b11111000010: c = 14'b00000110010010;
            11'b11111000000: c = 14'b00000100001010;
            11'b11101011000: c = 14'b00001010000011;
            11'b11010011011: begin c = en ? 14'b00000011000010 : 14'b0; l = en; end
            11'b11010011010: begin c = en ? 14'b00000011000110 : 14'b0; l = en; end
            default:         begin c = 14'b0; l = 1'b0; end
        endcase
    endtask

    task automatic modelEdge(input logic r, input logic iv, input logic [10:0] op,
                             input logic st, input logic fl, input logic fz);
        logic [13:0] c, c1;
        logic l, l1;
        int kill;
        if (!r) begin
            for (int k = 0; k < NS; k++) begin mV[k] = 0; mC[k] = 0; mO[k] = 0; end
            mIll = 0; mIll1 = 0; mCnt = 0; mCnt1 = 0;
            sb.delete();
        end else if (fz) begin
            mIll = 0; mIll1 = 0;
        end else if (fl) begin
            kill = 0;
            for (int k = 0; k < FD - 1; k++) if (mV[k]) kill++;
            for (int k = 0; k < kill; k++) void'(sb.pop_back());
            for (int k = NS - 1; k >= 1; k--) begin
                if (k < FD) begin mV[k] = 0; mC[k] = 0; mO[k] = 0; end
                else begin mV[k] = mV[k-1]; mC[k] = mC[k-1]; mO[k] = mO[k-1]; end
            end
            mV[0] = 0; mC[0] = 0; mO[0] = 0;
            mIll = 0; mIll1 = 0;
        end else if (st) begin
            for (int k = NS - 1; k >= 1; k--) begin mV[k] = mV[k-1]; mC[k] = mC[k-1]; mO[k] = mO[k-1]; end
            mV[0] = 0; mC[0] = 0; mO[0] = 0;
            mIll = 0; mIll1 = 0;
        end else begin
            tbDec(op, 1'b1, c, l);
            tbDec(op, 1'b0, c1, l1);
            for (int k = NS - 1; k >= 1; k--) begin mV[k] = mV[k-1]; mC[k] = mC[k-1]; mO[k] = mO[k-1]; end
            mV[0] = iv & l; mC[0] = c; mO[0] = op;
            mIll  = iv & ~l;
            mIll1 = iv & ~l1;
            if (mIll  && mCnt  < (1 << CW) - 1) mCnt++;
            if (mIll1 && mCnt1 < (1 << CW) - 1) mCnt1++;
            if (iv & l) sb.push_back({op, c});
        end
    endtask

    task automatic compareAll(input string tag, input logic r, input logic fz);
        logic [NS-1:0]    ev;
        logic [NS*14-1:0] ec;
        logic [24:0]      e;
        for (int k = 0; k < NS; k++) begin
            ev[k] = mV[k];
            ec[k*14 +: 14] = mV[k] ? mC[k] : 14'b0;
        end
        chk({tag, "_valid"}, 64'(sv0), 64'(ev));
        chk({tag, "_ctrl"}, 64'(sc0), 64'(ec));
        for (int k = 0; k < NS; k++)
            if (mV[k]) chk($sformatf("%s_op%0d", tag, k), 64'(so0[k*11 +: 11]), 64'(mO[k]));
        chk({tag, "_ill"}, 64'(ill0), 64'(mIll));
        chk({tag, "_cnt"}, 64'(cnt0), 64'(mCnt));
        chk({tag, "_ill_noshift"}, 64'(ill1), 64'(mIll1));
        chk({tag, "_cnt_noshift"}, 64'(cnt1), 64'(mCnt1));
        // Scoreboard: a new WB-stage entry appears only on a shifting edge.
        if (r && !fz && sv0[NS-1] === 1'b1) begin
            if (sb.size() == 0) begin
                chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                chk({tag, "_sb_wb"}, 64'({so0[(NS-1)*11 +: 11], sc0[(NS-1)*14 +: 14]}), 64'(e));
            end
        end
    endtask

    task automatic step(input string tag, input logic r, input logic iv, input logic [10:0] op,
                        input logic st, input logic fl, input logic fz);
        @(negedge clk);
        rst = r; id_valid = iv; opcode = op; stall = st; flush = fl; freeze = fz;
        @(posedge clk);
        modelEdge(r, iv, op, st, fl, fz);
        #1;
        compareAll(tag, r, fz);
    endtask

    initial begin
        rst = 1'b0; id_valid = 1'b1; opcode = LDUR_OP; stall = 1'b0; flush = 1'b0; freeze = 1'b0;

        // 1. Reset with a live LDUR on ID
        step("rst0", 0, 1, LDUR_OP, 0, 0, 0);
        step("rst1", 0, 1, LDUR_OP, 0, 0, 0);
        chk("rst_opcode_zero", 64'(so0), 64'd0);
        step("ldur_first", 1, 1, LDUR_OP, 0, 0, 0);
        chk("ldur_stage0_ctrl", 64'(sc0[13:0]), 64'b00000110010010);

        // 2. Back-to-back stream
        step("s_addi", 1, 1, ADDI_OP, 0, 0, 0);
        step("s_stur", 1, 1, STUR_OP, 0, 0, 0);
        chk("stream_all_valid", 64'(sv0), 64'b111);
        step("s_subs", 1, 1, SUBS_OP, 0, 0, 0);
        step("s_idle0", 1, 0, SUBS_OP, 0, 0, 0);
        step("s_idle1", 1, 0, 11'd0, 0, 0, 0);

        // 3. One-cycle stall between LDUR and ADDS
        step("st_ldur", 1, 1, LDUR_OP, 0, 0, 0);
        step("st_stall", 1, 1, ADDS_OP, 1, 0, 0);
        chk("stall_bubble_valid", 64'(sv0[0]), 64'd0);
        step("st_adds", 1, 1, ADDS_OP, 0, 0, 0);
        step("st_idle", 1, 0, 11'd0, 0, 0, 0);

        // 4. Flush with CBZ/ADDI/STUR in flight; B on ID is dropped
        step("fl_cbz", 1, 1, CBZ_OP, 0, 0, 0);
        step("fl_addi", 1, 1, ADDI_OP, 0, 0, 0);
        step("fl_stur", 1, 1, STUR_OP, 0, 0, 0);
        step("fl_flush", 1, 1, B_OP, 0, 1, 0);
        chk("flush_s01_bubble", 64'(sv0[1:0]), 64'b00);
        step("fl_idle0", 1, 0, 11'd0, 0, 0, 0);
        step("fl_idle1", 1, 0, 11'd0, 0, 0, 0);
        step("fl_both", 1, 1, ADDS_OP, 1, 1, 0);

        // 5. Freeze three cycles with flush, stall and an illegal op asserted
        step("fz_addi", 1, 1, ADDI_OP, 0, 0, 0);
        step("fz_subs", 1, 1, SUBS_OP, 0, 0, 0);
        step("fz_ldur", 1, 1, LDUR_OP, 0, 0, 0);
        for (int i = 0; i < 3; i++) step($sformatf("fz_hold%0d", i), 1, 1, BAD_OP, 1, 1, 1);
        chk("freeze_held_valid", 64'(sv0), 64'b111);
        step("fz_rel0", 1, 1, BL_OP, 0, 0, 0);
        step("fz_rel1", 1, 1, BR_OP, 0, 0, 0);
        step("fz_rel2", 1, 1, BC_OP, 0, 0, 0);
        step("fz_rel3", 1, 1, B_OP, 0, 0, 0);

        // Shift ops: legal with EN_SHIFT=1, illegal in the EN_SHIFT=0 build
        step("sh_lsl", 1, 1, LSL_OP, 0, 0, 0);
        chk("lsl_noshift_illegal", 64'(ill1), 64'd1);
        step("sh_lsr", 1, 1, LSR_OP, 0, 0, 0);
        step("sh_bad_idle", 1, 0, BAD_OP, 0, 0, 0);
        step("sh_idle", 1, 0, 11'd0, 0, 0, 0);
        step("sh_idle2", 1, 0, 11'd0, 0, 0, 0);

        // 6. Illegal opcode stream to saturation
        for (int i = 0; i < (1 << CW) + 2; i++) begin
            step($sformatf("sat%0d", i), 1, 1, BAD_OP, 0, 0, 0);
            chk($sformatf("sat%0d_illegal", i), 64'(ill0), 64'd1);
        end
        chk("sat_cnt_max", 64'(cnt0), 64'd15);

        // Reset mid-operation discards in-flight control
        step("mr_addi", 1, 1, ADDI_OP, 0, 0, 0);
        step("mr_subs", 1, 1, SUBS_OP, 0, 0, 0);
        step("mr_rst", 0, 1, STUR_OP, 0, 0, 0);
        chk("midrst_valid_zero", 64'(sv0), 64'd0);
        chk("midrst_cnt_zero", 64'(cnt0), 64'd0);
        step("mr_after", 1, 1, STUR_OP, 0, 0, 0);
        step("mr_end", 1, 0, 11'd0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
